mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage: consumes the EX/MEM register outputs, performs word/byte load-store over a req/ack data bus.
//  Holds the pipeline via mem_stall while an access is outstanding, then registers results into the MEM/WB boundary.
//  Adds lane steering, sign extension and bus timeout detection.
// PARAMETERS
//  TIMEOUT_CYCLES  15  cycles in WAIT without dmem_ack before bus_err (1..2^TIMEOUT_W-1)
//  TIMEOUT_W       4   width of timeout counter
// PORTS
//  clk             in   1   clock; all flops update on negedge clk, matching the pipeline registers
//  rst             in   1   reset; one clock; reset is synchronous and active-high
//  alu_result_mem  in   32  effective address / pass-through ALU result
//  alu_src_2_mem   in   32  store data
//  reg_w_addr_mem  in   5   destination register
//  mem_ctrl_mem    in   3   [1:0] op: 00 none, 01 load, 10 store, 11 none; [2] 1=byte, 0=word
//  wb_ctrl_mem     in   3   WB control, passed through
//  dmem_req        out  1   bus request
//  dmem_we         out  1   1=store
//  dmem_addr       out  32  bus address
//  dmem_wdata      out  32  store data, lane-replicated
//  dmem_be         out  4   byte enables
//  dmem_rdata      in   32  load data, valid with dmem_ack
//  dmem_ack        in   1   transfer complete
//  mem_stall       out  1   hold upstream stages (combinational)
//  mem_rdata_wb    out  32  aligned, sign-extended load data
//  alu_result_wb   out  32  registered alu_result_mem
//  reg_w_addr_wb   out  5   registered destination
//  wb_ctrl_wb      out  3   registered WB control; 0 = bubble
//  bus_err         out  1   one-cycle pulse on timeout
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, all *_wb=0, bus_err=0. dmem_req=0 while rst=1; a reset in WAIT abandons the access.
//  - FSM IDLE/WAIT. access = op in {01,10}, non-erroring.
//  - IDLE, no access: *_wb capture inputs every edge; mem_stall=0; dmem_req=0.
//  - IDLE, access: dmem_req=1 combinationally.
//    - dmem_ack same cycle: zero-wait completion, mem_stall=0, *_wb capture, stay IDLE.
//    - otherwise mem_stall=1 and go WAIT.
//  - WAIT: dmem_req=1; addr/we/wdata/be held stable from inputs (upstream frozen by stall).
//    - Each edge without ack: counter+1 and wb_ctrl_wb=0 (bubble).
//    - ack: mem_stall=0, capture (load data steered), counter=0, go IDLE.
//    - counter reaches TIMEOUT_CYCLES-1 without ack: bus_err pulse, wb_ctrl_wb=0, dmem_req drops next cycle, go IDLE; mem_stall=0 on that cycle.
//  - Late ack arriving in IDLE with no request is ignored.
//  - Word access: dmem_be=4'b1111, dmem_wdata=alu_src_2_mem.
//  - Byte access: dmem_be=4'b0001<<addr[1:0], wdata={4{src2[7:0]}}; load selects lane addr[1:0] (little-endian), sign-extends bit 7.
//  - Store: mem_rdata_wb=0.
//  - Lane steering is combinational; latency is ack edge -> *_wb valid one negedge later.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: word access with addr[1:0]!=0 issues no request, output misalign_err (1-bit port, present only with macro) pulses 1 cycle, wb_ctrl_wb=0, no stall.
//  Undefined: dmem_addr[1:0] forced to 00 for word accesses; access proceeds normally.
// STRUCTURE
//  Package mips_mem_pkg: MEM_OP_NONE/LOAD/STORE encodings, mem_ctrl bit indices, state enum {IDLE,WAIT}, BE_WORD constant.
//  Sub-module load_store_align: combinational be/wdata generation and load lane select + sign extension.
// TESTING
//  1 op=00, alu_result=0x1234 -> next edge alu_result_wb=0x1234, no dmem_req, mem_stall=0.
//  2 word load addr 0x100, ack same cycle, rdata=0xDEADBEEF -> mem_stall never 1, mem_rdata_wb=0xDEADBEEF.
//  3 byte load addr 0x103, ack after 3 cycles, rdata=0x80112233 -> be=1000, 3 bubbles, mem_rdata_wb=0xFFFFFF80.
//  4 byte store addr 0x201, src2=0xAB -> be=0010, wdata=0xABABABAB, we=1.
//  5 no ack for 15 cycles -> bus_err pulse once, wb_ctrl_wb=0, back to IDLE, stall released.
//  6 rst mid-WAIT -> dmem_req=0 that cycle, all *_wb=0 next edge.
//  7 macro on: word load addr 0x102 -> misalign_err pulse, no dmem_req; macro off: dmem_addr=0x100.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM pipeline stage.
//   MEM_OP_*       : mem_ctrl[1:0] operation codes
//   MEM_CTRL_*     : bit positions inside the 3-bit mem_ctrl field
//   mem_state_e    : bus access FSM states
//   BE_WORD        : byte-enable pattern for a full word transfer
//   sext8          : sign-extend a load byte to 32 bits
package mips_mem_pkg;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
  localparam logic [1:0] MEM_OP_STORE = 2'b10;

  localparam int MEM_CTRL_OP_LSB = 0;
  localparam int MEM_CTRL_OP_MSB = 1;
  localparam int MEM_CTRL_BYTE   = 2;

  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  function automatic logic signed [31:0] sext8(input logic signed [7:0] b);
    return 32'(b);
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering for byte/word accesses.
// Ports:
//   addr_lo  in  2   low address bits selecting the byte lane
//   is_byte  in  1   1 = byte access, 0 = word access
//   st_data  in  32  raw store data from the register file
//   rdata    in  32  raw bus read data
//   be       out 4   byte enables
//   wdata    out 32  store data, byte replicated to all lanes for byte stores
//   ld_data  out 32  load data, lane selected and sign extended for byte loads
module load_store_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic        is_byte,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0] w_lane;

  // Little-endian: lane 0 is rdata[7:0]
  always_comb begin
    w_lane = rdata[7:0];
    case (addr_lo)
      2'd0:    w_lane = rdata[7:0];
      2'd1:    w_lane = rdata[15:8];
      2'd2:    w_lane = rdata[23:16];
      default: w_lane = rdata[31:24];
    endcase
  end

  always_comb begin
    be      = BE_WORD;
    wdata   = st_data;
    ld_data = rdata;
    if (is_byte) begin
      be      = 4'b0001 << addr_lo;
      wdata   = {4{st_data[7:0]}};
      ld_data = sext8(w_lane);
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a req/ack data bus for loads/stores coming out
// of EX/MEM, stalls the pipeline while an access is outstanding, and
// registers the results into the MEM/WB boundary. All flops use negedge clk.
// Optional build macro: MEM_MISALIGN_TRAP_EN (adds misalign_err port; a
// misaligned word access is trapped instead of being aligned down).
// Ports:
//   clk, rst                  clock (negedge active), sync active-high reset
//   alu_result_mem [31:0]     effective address / ALU pass-through
//   alu_src_2_mem  [31:0]     store data
//   reg_w_addr_mem [4:0]      destination register
//   mem_ctrl_mem   [2:0]      [1:0] op, [2] byte
//   wb_ctrl_mem    [2:0]      WB control
//   dmem_req/we/addr/wdata/be bus request side
//   dmem_rdata/dmem_ack       bus response side
//   mem_stall                 combinational upstream hold
//   mem_rdata_wb, alu_result_wb, reg_w_addr_wb, wb_ctrl_wb   MEM/WB outputs
//   bus_err                   one-cycle pulse after a bus timeout
//   misalign_err              one-cycle pulse (only with MEM_MISALIGN_TRAP_EN)
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TIMEOUT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] alu_src_2_mem,
  input  logic [4:0]  reg_w_addr_mem,
  input  logic [2:0]  mem_ctrl_mem,
  input  logic [2:0]  wb_ctrl_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic [31:0] mem_rdata_wb,
  output logic [31:0] alu_result_wb,
  output logic [4:0]  reg_w_addr_wb,
  output logic [2:0]  wb_ctrl_wb,
  output logic        bus_err
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e           r_state, w_state_nx;
  logic [TIMEOUT_W-1:0] r_cnt, w_cnt_nx;

  logic [1:0]  w_op;
  logic        w_is_byte;
  logic        w_is_ls;
  logic        w_misalign;
  logic        w_misalign_trap;
  logic        w_access;
  logic        w_req;
  logic        w_timeout;
  logic        w_done_load;
  logic [31:0] w_ld_data;

  assign w_op      = mem_ctrl_mem[MEM_CTRL_OP_MSB:MEM_CTRL_OP_LSB];
  assign w_is_byte = mem_ctrl_mem[MEM_CTRL_BYTE];
  assign w_is_ls   = (w_op == MEM_OP_LOAD) || (w_op == MEM_OP_STORE);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = w_is_ls && !w_is_byte && (alu_result_mem[1:0] != 2'b00);
  assign dmem_addr  = alu_result_mem;
`else
  assign w_misalign = 1'b0;
  // Word accesses ignore the low address bits
  assign dmem_addr  = {alu_result_mem[31:2], w_is_byte ? alu_result_mem[1:0] : 2'b00};
`endif

  // Only evaluated in IDLE; in WAIT the inputs are the already-accepted access
  assign w_misalign_trap = (r_state == IDLE) && w_misalign;
  assign w_access        = w_is_ls && !w_misalign;

  assign w_req     = !rst && ((r_state == WAIT) || w_access);
  assign w_timeout = !rst && (r_state == WAIT) && !dmem_ack && (r_cnt == CNT_LAST);
  assign mem_stall = w_req && !dmem_ack && !w_timeout;
  // An ack with no request outstanding is ignored
  assign w_done_load = w_req && dmem_ack && (w_op == MEM_OP_LOAD);

  assign dmem_req = w_req;
  assign dmem_we  = w_req && (w_op == MEM_OP_STORE);

  load_store_align u_align (
    .addr_lo (alu_result_mem[1:0]),
    .is_byte (w_is_byte),
    .st_data (alu_src_2_mem),
    .rdata   (dmem_rdata),
    .be      (dmem_be),
    .wdata   (dmem_wdata),
    .ld_data (w_ld_data)
  );

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_nx = '0;
        if (w_access && !dmem_ack) w_state_nx = WAIT;
      end
      WAIT: begin
        if (dmem_ack || w_timeout) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // MEM/WB boundary: capture when not stalled, inject a bubble otherwise
  always_ff @(negedge clk) begin
    if (rst) begin
      mem_rdata_wb  <= '0;
      alu_result_wb <= '0;
      reg_w_addr_wb <= '0;
      wb_ctrl_wb    <= '0;
      bus_err       <= 1'b0;
    end else begin
      bus_err <= w_timeout;
      if (mem_stall) begin
        wb_ctrl_wb <= '0;
      end else begin
        alu_result_wb <= alu_result_mem;
        reg_w_addr_wb <= reg_w_addr_mem;
        wb_ctrl_wb    <= (w_timeout || w_misalign_trap) ? 3'b000 : wb_ctrl_mem;
        mem_rdata_wb  <= w_done_load ? w_ld_data : 32'h0;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(negedge clk) begin
    if (rst) misalign_err <= 1'b0;
    else     misalign_err <= w_misalign_trap;
  end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_mem, alu_src_2_mem, dmem_rdata;
  logic [4:0]  reg_w_addr_mem;
  logic [2:0]  mem_ctrl_mem, wb_ctrl_mem;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, mem_stall, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, mem_rdata_wb, alu_result_wb;
  logic [3:0]  dmem_be;
  logic [4:0]  reg_w_addr_wb;
  logic [2:0]  wb_ctrl_wb;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk            (clk),
    .rst            (rst),
    .alu_result_mem (alu_result_mem),
    .alu_src_2_mem  (alu_src_2_mem),
    .reg_w_addr_mem (reg_w_addr_mem),
    .mem_ctrl_mem   (mem_ctrl_mem),
    .wb_ctrl_mem    (wb_ctrl_mem),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_be        (dmem_be),
    .dmem_rdata     (dmem_rdata),
    .dmem_ack       (dmem_ack),
    .mem_stall      (mem_stall),
    .mem_rdata_wb   (mem_rdata_wb),
    .alu_result_wb  (alu_result_wb),
    .reg_w_addr_wb  (reg_w_addr_wb),
    .wb_ctrl_wb     (wb_ctrl_wb),
    .bus_err        (bus_err)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_err   (misalign_err)
`endif
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] src2;
    logic [4:0]  rd;
    logic [2:0]  ctrl;
    logic [2:0]  wbc;
    logic [31:0] rdata;
    logic        ack;
    logic        e_req;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_addr;
    logic [31:0] e_rdwb;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Advance past the active (falling) edge
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] src2, input logic [4:0] rd,
                       input logic [2:0] ctrl, input logic [2:0] wbc,
                       input logic [31:0] rdata, input logic ack);
    alu_result_mem = alu;
    alu_src_2_mem  = src2;
    reg_w_addr_mem = rd;
    mem_ctrl_mem   = ctrl;
    wb_ctrl_mem    = wbc;
    dmem_rdata     = rdata;
    dmem_ack       = ack;
    #1;
  endtask

  initial begin
    int brk;
    int errs;

    //            alu           src2          rd  ctrl    wbc     rdata         ack  req  we   be       wdata         addr          rdwb
    vecs[0] = '{32'h0000_1234, 32'h0,        5,  3'b000, 3'b101, 32'h0,        0,   0,   0,   4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[1] = '{32'h0000_0100, 32'h0,        7,  3'b001, 3'b011, 32'hDEADBEEF, 1,   1,   0,   4'b1111, 32'h0,        32'h0000_0100, 32'hDEADBEEF};
    vecs[2] = '{32'h0000_0201, 32'h0000_00AB, 0, 3'b110, 3'b100, 32'h0,        1,   1,   1,   4'b0010, 32'hABABABAB, 32'h0000_0201, 32'h0};
    vecs[3] = '{32'h0000_0102, 32'h0,        9,  3'b101, 3'b011, 32'h80112233, 1,   1,   0,   4'b0100, 32'h0,        32'h0000_0102, 32'h0000_0011};
    vecs[4] = '{32'h0000_0100, 32'h0,        10, 3'b101, 3'b011, 32'h123456F0, 1,   1,   0,   4'b0001, 32'h0,        32'h0000_0100, 32'hFFFFFFF0};
    vecs[5] = '{32'h0000_0300, 32'hCAFEF00D, 0,  3'b010, 3'b100, 32'h0,        1,   1,   1,   4'b1111, 32'hCAFEF00D, 32'h0000_0300, 32'h0};
    vecs[6] = '{32'h0000_0055, 32'h0,        3,  3'b011, 3'b110, 32'h12345678, 1,   0,   0,   4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[7] = '{32'h0000_0066, 32'h0,        4,  3'b000, 3'b010, 32'hFFFFFFFF, 1,   0,   0,   4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[8] = '{32'h0000_0203, 32'h1234567F, 0,  3'b110, 3'b100, 32'h0,        1,   1,   1,   4'b1000, 32'h7F7F7F7F, 32'h0000_0203, 32'h0};

    // Reset with an access presented: no request may leave
    rst = 1'b1;
    drive(32'h100, 32'h0, 5'd1, 3'b001, 3'b111, 32'h0, 1'b0);
    step();
    step();
    chk("rst_req", {31'b0, dmem_req}, 32'h0);
    chk("rst_stall", {31'b0, mem_stall}, 32'h0);
    chk("rst_alu_wb", alu_result_wb, 32'h0);
    chk("rst_rdata_wb", mem_rdata_wb, 32'h0);
    chk("rst_rd_wb", {27'b0, reg_w_addr_wb}, 32'h0);
    chk("rst_wbc_wb", {29'b0, wb_ctrl_wb}, 32'h0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'h0);
    rst = 1'b0;

    // Single-cycle vectors: no access, zero-wait access, or ignored late ack
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].alu, vecs[i].src2, vecs[i].rd, vecs[i].ctrl, vecs[i].wbc, vecs[i].rdata, vecs[i].ack);
      chk($sformatf("v%0d_req", i), {31'b0, dmem_req}, {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d_stall", i), {31'b0, mem_stall}, 32'h0);
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_we", i), {31'b0, dmem_we}, {31'b0, vecs[i].e_we});
        chk($sformatf("v%0d_be", i), {28'b0, dmem_be}, {28'b0, vecs[i].e_be});
        chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].e_addr);
        if (vecs[i].e_we) chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].e_wdata);
      end
      step();
      chk($sformatf("v%0d_alu_wb", i), alu_result_wb, vecs[i].alu);
      chk($sformatf("v%0d_rd_wb", i), {27'b0, reg_w_addr_wb}, {27'b0, vecs[i].rd});
      chk($sformatf("v%0d_wbc_wb", i), {29'b0, wb_ctrl_wb}, {29'b0, vecs[i].wbc});
      chk($sformatf("v%0d_rdata_wb", i), mem_rdata_wb, vecs[i].e_rdwb);
    end

    // Byte load from 0x103, ack on the fourth request cycle: three bubbles
    drive(32'h103, 32'h0, 5'd17, 3'b101, 3'b111, 32'h0, 1'b0);
    chk("bl_be", {28'b0, dmem_be}, 32'h8);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bl_req_%0d", i), {31'b0, dmem_req}, 32'h1);
      chk($sformatf("bl_stall_%0d", i), {31'b0, mem_stall}, 32'h1);
      step();
      chk($sformatf("bl_bubble_%0d", i), {29'b0, wb_ctrl_wb}, 32'h0);
    end
    drive(32'h103, 32'h0, 5'd17, 3'b101, 3'b111, 32'h80112233, 1'b1);
    chk("bl_ack_stall", {31'b0, mem_stall}, 32'h0);
    chk("bl_ack_be", {28'b0, dmem_be}, 32'h8);
    step();
    chk("bl_rdata_wb", mem_rdata_wb, 32'hFFFFFF80);
    chk("bl_wbc_wb", {29'b0, wb_ctrl_wb}, 32'h7);
    chk("bl_rd_wb", {27'b0, reg_w_addr_wb}, 32'd17);

    // Timeout: stall released on the 16th request cycle, then bus_err pulse
    drive(32'h400, 32'h0, 5'd2, 3'b001, 3'b011, 32'h0, 1'b0);
    brk = -1;
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_err) errs++;
      if (!mem_stall) begin
        brk = i;
        break;
      end
      step();
    end
    chk("to_release_cycle", brk, 32'd15);
    chk("to_req_on_release", {31'b0, dmem_req}, 32'h1);
    chk("to_no_early_err", errs, 32'h0);
    step();
    drive(32'h777, 32'h0, 5'd12, 3'b000, 3'b011, 32'h0, 1'b0);
    chk("to_bus_err", {31'b0, bus_err}, 32'h1);
    chk("to_wbc_wb", {29'b0, wb_ctrl_wb}, 32'h0);
    chk("to_req_dropped", {31'b0, dmem_req}, 32'h0);
    chk("to_stall", {31'b0, mem_stall}, 32'h0);
    step();
    chk("to_pulse_end", {31'b0, bus_err}, 32'h0);
    chk("to_after_wbc", {29'b0, wb_ctrl_wb}, 32'h3);
    chk("to_after_alu", alu_result_wb, 32'h777);

    // Reset while in WAIT abandons the access
    drive(32'h500, 32'h1, 5'd6, 3'b010, 3'b100, 32'h0, 1'b0);
    chk("rw_stall", {31'b0, mem_stall}, 32'h1);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rw_req_in_rst", {31'b0, dmem_req}, 32'h0);
    step();
    chk("rw_alu_wb", alu_result_wb, 32'h0);
    chk("rw_rd_wb", {27'b0, reg_w_addr_wb}, 32'h0);
    chk("rw_wbc_wb", {29'b0, wb_ctrl_wb}, 32'h0);
    rst = 1'b0;
    drive(32'h88, 32'h0, 5'd8, 3'b000, 3'b001, 32'h5555AAAA, 1'b1);
    chk("rw_idle_req", {31'b0, dmem_req}, 32'h0);
    chk("rw_idle_stall", {31'b0, mem_stall}, 32'h0);
    step();
    chk("rw_late_ack_rdata", mem_rdata_wb, 32'h0);
    chk("rw_late_ack_wbc", {29'b0, wb_ctrl_wb}, 32'h1);
    chk("rw_late_ack_alu", alu_result_wb, 32'h88);

    // Misaligned word load
`ifdef MEM_MISALIGN_TRAP_EN
    drive(32'h102, 32'h0, 5'd3, 3'b001, 3'b111, 32'h11223344, 1'b0);
    chk("ma_req", {31'b0, dmem_req}, 32'h0);
    chk("ma_stall", {31'b0, mem_stall}, 32'h0);
    step();
    drive(32'h0, 32'h0, 5'd0, 3'b000, 3'b010, 32'h0, 1'b0);
    chk("ma_err", {31'b0, misalign_err}, 32'h1);
    chk("ma_wbc_wb", {29'b0, wb_ctrl_wb}, 32'h0);
    step();
    chk("ma_err_end", {31'b0, misalign_err}, 32'h0);
`else
    drive(32'h102, 32'h0, 5'd3, 3'b001, 3'b111, 32'h11223344, 1'b1);
    chk("ma_req", {31'b0, dmem_req}, 32'h1);
    chk("ma_addr", dmem_addr, 32'h100);
    chk("ma_be", {28'b0, dmem_be}, 32'hF);
    step();
    chk("ma_rdata_wb", mem_rdata_wb, 32'h11223344);
    chk("ma_wbc_wb", {29'b0, wb_ctrl_wb}, 32'h7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
